// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_arbiter_pkg: shared GPR index/word types and the writeback request bundle
package gpr_wb_arbiter_pkg;
    localparam int GPR_COUNT = 32;
    typedef logic [4:0] Reg_index;
    typedef logic [31:0] Word;
    typedef struct packed {
        logic     valid;
        Reg_index sel;
        Word      data;
    } Wb_req;
endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: requester handshake bundle plus the two GPR write ports
//   master: drives req_valid/req_sel/req_data, observes req_ready and the write ports
//   slave : the arbiter side
interface gpr_wb_arbiter_if
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]     req_valid;
    Reg_index [NUM_REQ-1:0] req_sel;
    Word [NUM_REQ-1:0]      req_data;
    logic [NUM_REQ-1:0]     req_ready;
    Reg_index               gpr_sel_dest;
    logic                   gpr_we;
    Word                    gpr_dest;
    Reg_index               gpr_sel_dest_2;
    logic                   gpr_we_2;
    Word                    gpr_dest_2;
    modport master (
        output req_valid, req_sel, req_data,
        input  req_ready, gpr_sel_dest, gpr_we, gpr_dest, gpr_sel_dest_2, gpr_we_2, gpr_dest_2
    );
    modport slave (
        input  req_valid, req_sel, req_data,
        output req_ready, gpr_sel_dest, gpr_we, gpr_dest, gpr_sel_dest_2, gpr_we_2, gpr_dest_2
    );
endinterface

// File: rtl/gpr_wb_arbiter_rr_pick.sv
// gpr_wb_arbiter_rr_pick: rotating-priority first-one finder
//   mask  : candidate bits
//   ptr   : highest-priority position, scan wraps modulo N
//   found : any mask bit set
//   index : first set bit at or after ptr
module gpr_wb_arbiter_rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] index
);
    function automatic logic [PW-1:0] wrap(input int j);
        return PW'(j >= N ? j - N : j);
    endfunction
    // Scan from the far end back towards ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[wrap(int'(ptr) + k)]) begin
                found = 1'b1;
                index = wrap(int'(ptr) + k);
            end
        end
    end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: grants up to two writeback requesters per cycle onto the GPR write ports
//   clk, reset : clock, synchronous active-high reset
//   hold       : pipeline freeze, blocks new grants
//   bus        : requester handshake in, registered GPR write ports out
//   inflight   : GPRs accepted but not yet written
//   rr_ptr     : current highest-priority requester
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int   NUM_REQ           = 4,
    parameter logic SINGLE_WRITE_PORT = 1'b0,
    localparam int  PW                = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    gpr_wb_arbiter_if.slave      bus,
    output logic [GPR_COUNT-1:0] inflight,
    output logic [PW-1:0]        rr_ptr
);
    Wb_req [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0]  mask1, mask2;
    logic                found1, found2, found2_raw;
    logic [PW-1:0]       idx1, idx2;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GPR_COUNT-1:0] inflight_q, inflight_d;
    logic                we_q, we_d, we2_q, we2_d;
    Reg_index            sel_q, sel_d, sel2_q, sel2_d;
    Word                 data_q, data_d, data2_q, data2_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req[i] = '{valid: bus.req_valid[i], sel: bus.req_sel[i], data: bus.req_data[i]};
    end

    assign mask1 = (hold || reset) ? '0 : bus.req_valid;

    // Port 2 excludes the port-1 winner and anyone writing the same GPR.
    always_comb begin
        mask2 = '0;
        for (int i = 0; i < NUM_REQ; i++)
            mask2[i] = mask1[i] && (PW'(i) != idx1) && (req[i].sel != req[idx1].sel);
    end

    gpr_wb_arbiter_rr_pick #(.N(NUM_REQ)) u_pick1 (.mask(mask1), .ptr(rr_ptr_q), .found(found1), .index(idx1));
    gpr_wb_arbiter_rr_pick #(.N(NUM_REQ)) u_pick2 (.mask(mask2), .ptr(rr_ptr_q), .found(found2_raw), .index(idx2));

    assign found2 = found2_raw && !SINGLE_WRITE_PORT;

    always_comb begin
        bus.req_ready = '0;
        inflight_d    = '0;
        if (found1) begin
            bus.req_ready[idx1]    = 1'b1;
            inflight_d[req[idx1].sel] = 1'b1;
        end
        if (found2) begin
            bus.req_ready[idx2]    = 1'b1;
            inflight_d[req[idx2].sel] = 1'b1;
        end
    end

    // Every accepted write retires the cycle after it is granted, so the next
    // inflight value is exactly this cycle's grants (set wins over clear).
    always_comb begin
        we_d     = found1;
        we2_d    = found2;
        sel_d    = found1 ? req[idx1].sel : sel_q;
        data_d   = found1 ? req[idx1].data : data_q;
        sel2_d   = found2 ? req[idx2].sel : sel2_q;
        data2_d  = found2 ? req[idx2].data : data2_q;
        rr_ptr_d = found2 ? PW'((int'(idx2) + 1) % NUM_REQ) :
                   found1 ? PW'((int'(idx1) + 1) % NUM_REQ) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            we_q       <= 1'b0;
            we2_q      <= 1'b0;
            sel_q      <= '0;
            sel2_q     <= '0;
            data_q     <= '0;
            data2_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            we_q       <= we_d;
            we2_q      <= we2_d;
            sel_q      <= sel_d;
            sel2_q     <= sel2_d;
            data_q     <= data_d;
            data2_q    <= data2_d;
        end
    end

    assign bus.gpr_we         = we_q;
    assign bus.gpr_sel_dest   = sel_q;
    assign bus.gpr_dest       = data_q;
    assign bus.gpr_we_2       = we2_q;
    assign bus.gpr_sel_dest_2 = sel2_q;
    assign bus.gpr_dest_2     = data2_q;
    assign inflight           = inflight_q;
    assign rr_ptr             = rr_ptr_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: scoreboard bench for the dual-port and single-port arbiter
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;
    localparam int N = 4;
    typedef struct packed {
        logic        we;
        Reg_index    sel;
        Word         data;
        logic        we2;
        Reg_index    sel2;
        Word         data2;
        logic [31:0] infl;
        logic [1:0]  ptr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] infl_a, infl_b;
    logic [1:0]  ptr_a, ptr_b;
    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    exp_t        sb[$];
    Reg_index    sb_b[$];

    gpr_wb_arbiter_if #(.NUM_REQ(N)) bus_a ();
    gpr_wb_arbiter_if #(.NUM_REQ(N)) bus_b ();

    gpr_wb_arbiter #(.NUM_REQ(N), .SINGLE_WRITE_PORT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .hold(hold), .bus(bus_a), .inflight(infl_a), .rr_ptr(ptr_a));
    gpr_wb_arbiter #(.NUM_REQ(N), .SINGLE_WRITE_PORT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .hold(hold), .bus(bus_b), .inflight(infl_b), .rr_ptr(ptr_b));

    always #5 clk = ~clk;

    // Reference arbitration: scan from p, first valid wins port 1, next valid
    // with a different destination wins port 2.
    function automatic void model(input logic [N-1:0] v, input logic [N-1:0][4:0] s,
                                  input int p, output int w1, output int w2);
        w1 = -1;
        w2 = -1;
        for (int k = 0; k < N; k++) begin
            int i = (p + k) % N;
            if (v[i]) begin
                if (w1 < 0) w1 = i;
                else if (w2 < 0 && s[i] != s[w1]) w2 = i;
            end
        end
    endfunction

    task automatic cycle_a(input bit drop, output logic [N-1:0] g);
        exp_t e, o;
        int   w1, w2;
        @(negedge clk);
        model(bus_a.req_valid, bus_a.req_sel, m_ptr, w1, w2);
        if (hold) begin
            w1 = -1;
            w2 = -1;
        end
        g = '0;
        e = '0;
        if (w1 >= 0) begin
            g[w1] = 1'b1;
            e.we = 1'b1;
            e.sel = bus_a.req_sel[w1];
            e.data = bus_a.req_data[w1];
            e.infl[bus_a.req_sel[w1]] = 1'b1;
            m_ptr = (w1 + 1) % N;
        end
        if (w2 >= 0) begin
            g[w2] = 1'b1;
            e.we2 = 1'b1;
            e.sel2 = bus_a.req_sel[w2];
            e.data2 = bus_a.req_data[w2];
            e.infl[bus_a.req_sel[w2]] = 1'b1;
            m_ptr = (w2 + 1) % N;
        end
        e.ptr = 2'(m_ptr);
        checks++;
        if (bus_a.req_ready !== g) begin
            errors++;
            $display("FAIL ready: got %b want %b", bus_a.req_ready, g);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        checks++;
        if (bus_a.gpr_we !== o.we || bus_a.gpr_we_2 !== o.we2) begin
            errors++;
            $display("FAIL we: got %b%b want %b%b", bus_a.gpr_we, bus_a.gpr_we_2, o.we, o.we2);
        end
        if (o.we) begin
            checks++;
            if (bus_a.gpr_sel_dest !== o.sel || bus_a.gpr_dest !== o.data) begin
                errors++;
                $display("FAIL port1: got %0d/%h want %0d/%h", bus_a.gpr_sel_dest, bus_a.gpr_dest, o.sel, o.data);
            end
        end
        if (o.we2) begin
            checks++;
            if (bus_a.gpr_sel_dest_2 !== o.sel2 || bus_a.gpr_dest_2 !== o.data2) begin
                errors++;
                $display("FAIL port2: got %0d/%h want %0d/%h", bus_a.gpr_sel_dest_2, bus_a.gpr_dest_2, o.sel2, o.data2);
            end
        end
        checks++;
        if (infl_a !== o.infl) begin
            errors++;
            $display("FAIL inflight: got %h want %h", infl_a, o.infl);
        end
        checks++;
        if (ptr_a !== o.ptr) begin
            errors++;
            $display("FAIL rr_ptr: got %0d want %0d", ptr_a, o.ptr);
        end
        if (drop) bus_a.req_valid = bus_a.req_valid & ~g;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold = 1'b0;
        bus_a.req_valid = '1;
        bus_b.req_valid = '1;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 4'b0 || bus_b.req_ready !== 4'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b/%b want 0000", bus_a.req_ready, bus_b.req_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_a.req_valid = '0;
        bus_b.req_valid = '0;
        m_ptr = 0;
        sb.delete();
        sb_b.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus_a.gpr_we, bus_a.gpr_we_2, bus_b.gpr_we, bus_b.gpr_we_2} !== 4'b0) begin
            errors++;
            $display("FAIL reset_we: got %b%b want 00", bus_a.gpr_we, bus_a.gpr_we_2);
        end
        checks++;
        if ({bus_a.gpr_sel_dest, bus_a.gpr_sel_dest_2, bus_a.gpr_dest, bus_a.gpr_dest_2} !== '0) begin
            errors++;
            $display("FAIL reset_ports: got %0d %0d %h %h want 0", bus_a.gpr_sel_dest, bus_a.gpr_sel_dest_2,
                     bus_a.gpr_dest, bus_a.gpr_dest_2);
        end
        checks++;
        if (infl_a !== 32'h0 || ptr_a !== 2'd0 || ptr_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got inflight %h rr_ptr %0d want 0 0", infl_a, ptr_a);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] g;
        do_reset();
        bus_a.req_sel = '0;
        bus_a.req_data = '0;
        bus_a.req_sel[0] = 5'd3;
        bus_a.req_sel[2] = 5'd7;
        bus_a.req_data[0] = 32'hA;
        bus_a.req_data[2] = 32'hB;
        bus_a.req_valid = 4'b0101;
        cycle_a(1'b1, g);
        checks++;
        if (bus_a.gpr_sel_dest !== 5'd3 || bus_a.gpr_dest !== 32'hA || bus_a.gpr_sel_dest_2 !== 5'd7
            || bus_a.gpr_dest_2 !== 32'hB || ptr_a !== 2'd3) begin
            errors++;
            $display("FAIL basic: got %0d/%h %0d/%h ptr %0d want 3/a 7/b ptr 3", bus_a.gpr_sel_dest,
                     bus_a.gpr_dest, bus_a.gpr_sel_dest_2, bus_a.gpr_dest_2, ptr_a);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus_a.req_sel[i] = 5'(i + 1);
            bus_a.req_data[i] = 32'(32'h100 + i);
        end
        bus_a.req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            cycle_a(1'b0, g);
            checks++;
            if (bus_a.gpr_sel_dest !== 5'(c % 2 == 0 ? 1 : 3) || bus_a.gpr_sel_dest_2 !== 5'(c % 2 == 0 ? 2 : 4)
                || ptr_a !== 2'(c % 2 == 0 ? 2 : 0)) begin
                errors++;
                $display("FAIL rotation%0d: got sel %0d/%0d ptr %0d", c, bus_a.gpr_sel_dest, bus_a.gpr_sel_dest_2, ptr_a);
            end
            for (int i = 0; i < N; i++) bus_a.req_data[i] = 32'(32'h200 + c * 16 + i);
        end
        bus_a.req_valid = '0;
    endtask

    task automatic test_conflict();
        logic [N-1:0] g;
        do_reset();
        bus_a.req_sel[0] = 5'd5;
        bus_a.req_sel[1] = 5'd5;
        bus_a.req_sel[2] = 5'd9;
        bus_a.req_data[0] = 32'hC0;
        bus_a.req_data[1] = 32'hC1;
        bus_a.req_data[2] = 32'hC2;
        bus_a.req_valid = 4'b0111;
        cycle_a(1'b1, g);
        checks++;
        if (infl_a[5] !== 1'b1 || infl_a[9] !== 1'b1 || bus_a.gpr_dest !== 32'hC0 || bus_a.gpr_dest_2 !== 32'hC2) begin
            errors++;
            $display("FAIL conflict1: got inflight %h data %h/%h", infl_a, bus_a.gpr_dest, bus_a.gpr_dest_2);
        end
        cycle_a(1'b1, g);
        checks++;
        if (infl_a[5] !== 1'b1 || bus_a.gpr_we !== 1'b1 || bus_a.gpr_dest !== 32'hC1 || bus_a.gpr_we_2 !== 1'b0
            || ptr_a !== 2'd2) begin
            errors++;
            $display("FAIL conflict2: got inflight %h we %b%b data %h ptr %0d", infl_a, bus_a.gpr_we,
                     bus_a.gpr_we_2, bus_a.gpr_dest, ptr_a);
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] g;
        do_reset();
        for (int i = 0; i < N; i++) bus_a.req_sel[i] = 5'(i + 1);
        bus_a.req_valid = 4'b1111;
        cycle_a(1'b0, g);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle_a(1'b0, g);
            checks++;
            if (ptr_a !== 2'd2 || bus_a.gpr_we !== 1'b0 || bus_a.gpr_we_2 !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: got ptr %0d we %b%b want 2 00", c, ptr_a, bus_a.gpr_we, bus_a.gpr_we_2);
            end
        end
        hold = 1'b0;
        cycle_a(1'b0, g);
        checks++;
        if (bus_a.gpr_sel_dest !== 5'd3 || bus_a.gpr_sel_dest_2 !== 5'd4 || ptr_a !== 2'd0) begin
            errors++;
            $display("FAIL hold_release: got %0d/%0d ptr %0d want 3/4 ptr 0", bus_a.gpr_sel_dest,
                     bus_a.gpr_sel_dest_2, ptr_a);
        end
        bus_a.req_valid = '0;
    endtask

    task automatic test_single();
        Reg_index s;
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus_b.req_sel[i] = 5'(10 + i);
            bus_b.req_data[i] = 32'(32'hB0 + i);
        end
        bus_b.req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus_b.req_ready !== 4'(1 << c)) begin
                errors++;
                $display("FAIL single_ready%0d: got %b want %b", c, bus_b.req_ready, 4'(1 << c));
            end
            sb_b.push_back(5'(10 + c));
            @(posedge clk);
            #1;
            s = sb_b.pop_front();
            checks++;
            if (bus_b.gpr_we !== 1'b1 || bus_b.gpr_we_2 !== 1'b0 || bus_b.gpr_sel_dest !== s
                || infl_b !== (32'h1 << s) || ptr_b !== 2'((c + 1) % N)) begin
                errors++;
                $display("FAIL single%0d: got we %b%b sel %0d inflight %h ptr %0d want 10 sel %0d", c,
                         bus_b.gpr_we, bus_b.gpr_we_2, bus_b.gpr_sel_dest, infl_b, ptr_b, s);
            end
        end
        bus_b.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        do_reset();
        bus_a.req_sel[1] = 5'd12;
        bus_a.req_data[1] = 32'h55;
        bus_a.req_valid = 4'b0010;
        cycle_a(1'b1, g);
        reset = 1'b1;
        bus_a.req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b want 0000", bus_a.req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.gpr_we !== 1'b0 || bus_a.gpr_we_2 !== 1'b0 || infl_a !== 32'h0 || ptr_a !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: got we %b%b inflight %h ptr %0d want 00 0 0", bus_a.gpr_we,
                     bus_a.gpr_we_2, infl_a, ptr_a);
        end
        reset = 1'b0;
        bus_a.req_valid = '0;
        m_ptr = 0;
    endtask

    initial begin
        bus_a.req_valid = '0;
        bus_a.req_sel = '0;
        bus_a.req_data = '0;
        bus_b.req_valid = '0;
        bus_b.req_sel = '0;
        bus_b.req_data = '0;
        test_reset();
        test_basic();
        test_rotation();
        test_conflict();
        test_hold();
        test_single();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the two GPR write ports of the register file between NUM_REQ writeback requesters: ALU, load unit, multiplier/divider and SPR-move path.
- Each cycle it grants up to two requests (one if SINGLE_WRITE_PORT), using rotating priority.
- Granted writes are registered onto the write-port signals of Register_file_if (gpr_sel_dest/gpr_we/gpr_dest and the _2 set).
- Sits between the execute-stage writeback sources and the register file's write modport.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- SINGLE_WRITE_PORT, 1'b0, when 1 only port 1 is used; gpr_we_2 is tied low.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  pipeline freeze; while high, no new grants are issued.
- req_valid  input  NUM_REQ  requester i has a write pending.
- req_sel  input  NUM_REQ x 5 (Reg_index)  destination GPR of requester i.
- req_data  input  NUM_REQ x 32 (Word)  write data of requester i.
- req_ready  output  NUM_REQ  grant to requester i; the write is accepted when req_valid[i] and req_ready[i] are both high.
- gpr_sel_dest  output  5  port 1 destination index.
- gpr_we  output  1  port 1 write enable.
- gpr_dest  output  32  port 1 write data.
- gpr_sel_dest_2  output  5  port 2 destination index.
- gpr_we_2  output  1  port 2 write enable.
- gpr_dest_2  output  32  port 2 write data.
- inflight  output  32  bit r set while a write to GPR r is accepted but not yet visible in the register file.
- rr_ptr  output  log2(NUM_REQ)  current highest-priority requester (debug).

Behaviour:
- Handshake: requesters hold valid, sel and data stable until ready. req_ready is combinational from req_valid, req_sel, rr_ptr and hold. It never depends on requester data.
- Arbitration order: requesters are scanned starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first valid requester wins port 1.
  - The next valid requester whose req_sel differs from the port-1 winner's req_sel wins port 2.
  - A requester targeting the same GPR as the port-1 winner is not granted and retries the next cycle, so there is never a same-cycle dual write to one register.
- If SINGLE_WRITE_PORT is 1, only the port-1 winner is granted.
- hold high: all req_ready are 0, rr_ptr is unchanged, and the output registers load we=0.
- Latency: one cycle. A request accepted in cycle t drives gpr_*_dest/gpr_we* in cycle t+1 and is written by the register file at the end of t+1.
- Output registers update every cycle:
  - sel and data load from the winner when a port is granted; otherwise they keep their old value.
  - we loads the grant.
- Port assignment is stable: the port-1 winner always appears on port 1 and the port-2 winner on port 2.
- rr_ptr update, when at least one grant occurs: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. With no grant, rr_ptr is held. This guarantees no starvation; any valid requester is granted within NUM_REQ cycles while hold is low.
- inflight update: bits are set for the indices granted in cycle t and cleared in cycle t+1 when those writes are on the ports. Set takes precedence over clear for the same bit in the same cycle. inflight equals the decoded {gpr_we ? gpr_sel_dest, gpr_we_2 ? gpr_sel_dest_2}.
- Reset values: gpr_we=0, gpr_we_2=0, gpr_sel_dest=0, gpr_sel_dest_2=0, gpr_dest=0, gpr_dest_2=0, rr_ptr=0, inflight=0. req_ready is 0 during reset.
- Reset mid-operation: writes registered but not yet performed are dropped (we cleared). Requesters must re-present after reset deasserts.
- GPR 0 is an ordinary register; there is no special zero handling.

Decomposition:
- Shared package (Pu_types): Reg_index and Word are reused. Add the constant GPR_COUNT=32 and the typedef Wb_req (struct: valid, sel, data) for the requester bundle.
- One sub-module: rr_pick. It is a combinational rotating-priority first-one finder with inputs (mask, ptr) and outputs (found, index). It is instantiated twice:
  - the second instance uses the mask with the first winner removed;
  - that mask is also filtered to remove requesters whose sel equals the first winner's sel.

Test Plan:
- Reset, then req_valid=4'b0101 with sel0=3, sel2=7, data 0xA, 0xB → ready=0101; next cycle gpr_we=1, sel=3, dest=0xA; gpr_we_2=1, sel_2=7, dest_2=0xB; rr_ptr=3.
- All four requesters valid, distinct sels, held for 4 cycles → grants alternate {0,1}, {2,3}, {0,1}, {2,3}; every requester is granted within 2 cycles.
- req0 and req1 both sel=5, req2 sel=9, rr_ptr=0 → grants req0 (port 1) and req2 (port 2); req1 is granted the following cycle; inflight bit 5 is set in each of those two cycles.
- hold=1 for 3 cycles with all requesters valid → ready=0, gpr_we=gpr_we_2=0, rr_ptr constant. Release hold → grants resume from the same rr_ptr.
- SINGLE_WRITE_PORT=1, req_valid=1111 → exactly one grant per cycle in order 0,1,2,3; gpr_we_2 is never 1.
- Assert reset in the cycle after a grant → gpr_we=0 next cycle, inflight=0, rr_ptr=0; the pending write is not performed.
